eth_tx_arbiter: RTL and testbench
=================================

# eth_tx_arbiter

Frame-granular round-robin arbiter sharing the single 100 Mb/s Ethernet transmit path among N byte-stream requesters (host DMA, control/pause generator, test pattern source). Sits between the requesters and the MAC transmit byte interface in the `clk` domain. Enforces an inter-frame idle gap and truncates oversize frames. Keeps frame and truncation counters.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (2..4).
- `IFG_CYCLES`, 12: idle cycles inserted after each frame (0 allowed).
- `MAX_LEN`, 1518: maximum forwarded bytes per frame.

Ports:
- `clk`  input  1  system clock.
- `rst`  input  1  synchronous, active-low reset (0 = reset).
- `s_tdata`  input  8*N_REQ  requester bytes; requester i occupies bits [8i+7:8i].
- `s_tvalid`  input  N_REQ  per-requester byte valid.
- `s_tlast`  input  N_REQ  per-requester last byte of frame.
- `s_tready`  output  N_REQ  per-requester byte accepted.
- `m_tdata`  output  8  byte to MAC.
- `m_tvalid`  output  1  byte valid to MAC.
- `m_tlast`  output  1  last byte of frame.
- `m_tuser`  output  1  frame error (truncated); valid only with `m_tlast`.
- `m_tready`  input  1  MAC accepts byte.
- `grant`  output  clog2(N_REQ)  index of current/last granted requester.
- `busy`  output  1  state is not IDLE.
- `frames_sent`  output  16  frames completed, including truncated frames; wraps.
- `frames_trunc`  output  16  frames truncated; wraps.

## Operation
- States: IDLE, XFER, DRAIN, IFG.
- IDLE: if any `s_tvalid` is high, pick the first requester with valid high, searching upward (mod N_REQ) from `last+1`. Register the pick into `grant`/`last`, clear the byte counter, go to XFER. No bytes move in IDLE.
- XFER (g = `grant`):
  - Pass-through combinational: `m_tdata`=`s_tdata[g]`, `m_tvalid`=`s_tvalid[g]`, `s_tready[g]`=`m_tready`.
  - `s_tready` of all other requesters is 0.
  - A beat is a handshake, i.e. `m_tvalid && m_tready`.
  - Byte counter (width clog2(MAX_LEN+1)) increments on each beat.
- Normal end: a beat with `s_tlast[g]`=1 and count < MAX_LEN.
  - `m_tlast`=1 and `m_tuser`=0 on that beat.
  - `frames_sent`++.
  - Next state is IFG, or IDLE if IFG_CYCLES=0.
- Truncation: the beat that brings the count to MAX_LEN.
  - `m_tlast` is forced to 1 and `m_tuser`=1 on that beat.
  - `frames_sent`++ and `frames_trunc`++.
  - If `s_tlast[g]` is also 1 on that beat: no truncation flag (`m_tuser`=0, `frames_trunc` unchanged), and go to IFG/IDLE.
  - Otherwise go to DRAIN.
- DRAIN: `m_tvalid`=0 and `s_tready[g]`=1; incoming bytes are discarded. A beat with `s_tlast[g]` moves to IFG/IDLE.
- IFG: all `s_tready`=0 and `m_tvalid`=0. Count IFG_CYCLES cycles, then go to IDLE.
- Fairness: the requester just served has lowest priority next arbitration. Requesters dropping valid mid-frame stall the MAC stream and do not end the frame.

## Timing
- Reset values:
  - state IDLE, `grant`=0, `last`=N_REQ-1 (requester 0 wins first).
  - byte and IFG counters 0.
  - `m_tvalid`=0, `m_tlast`=0, `m_tuser`=0, `m_tdata`=0, all `s_tready`=0.
  - `busy`=0, `frames_sent`=0, `frames_trunc`=0.
- Latency:
  - Valid seen in IDLE at cycle t gives a grant at t+1; the first byte is presentable at t+1 (XFER).
  - Zero-cycle data path in XFER.
- Frame-to-frame: last beat at cycle t, IFG occupies t+1..t+IFG_CYCLES, IDLE at t+IFG_CYCLES+1, next grant earliest one cycle later. Minimum MAC idle is therefore IFG_CYCLES+1 cycles.
- Counters update on the clock edge of the completing beat.
- Reset asserted mid-XFER or DRAIN: immediate return to reset values on that edge. The partial frame is abandoned with no `m_tlast`; the MAC handles the abort.
- Simultaneous valid on all requesters: strict rotation 0,1,...,N-1,0.

## Structure
- Package `eth_pkg`:
  - `arb_state_t` enum (IDLE, XFER, DRAIN, IFG).
  - Constants `ETH_MAX_LEN`=1518 and `ETH_IFG_BYTES`=12 (used as parameter defaults).
- Sub-module `eth_rr_arb`: combinational round-robin picker.
  - Inputs: req vector, last index.
  - Outputs: grant index, any-req.
- Top `eth_tx_arbiter` holds the FSM, byte and IFG counters, data mux and statistics counters. About 200 lines.

## Test plan
- Single frame, N=2: req0 sends 64 bytes with `m_tready`=1.
  - Grant 0; 64 beats; `m_tlast` on beat 64 with `m_tuser`=0; `frames_sent`=1.
  - 12 idle cycles, then IDLE.
- Contention: req0 and req1 both hold 3 back-to-back 60-byte frames.
  - Grant order 0,1,0,1,0,1; each gap is at least 13 cycles with `m_tvalid`=0; `frames_sent`=6.
- Backpressure: `m_tready` random 50%, req1 sends a 100-byte frame.
  - Output byte sequence matches input exactly.
  - `s_tready[1]` mirrors `m_tready`; `s_tready[0]` stays 0.
- Truncation, MAX_LEN=1518: req0 sends 1600 bytes.
  - Beat 1518 has `m_tlast`=1 and `m_tuser`=1.
  - 82 bytes are drained with `m_tvalid`=0.
  - `frames_trunc`=1, `frames_sent`=1.
- Exact-length frame: 1518 bytes with `tlast` on byte 1518.
  - `m_tuser`=0, `frames_trunc`=0, no DRAIN.
- Reset mid-frame: `rst`=0 at byte 30.
  - Next cycle: `m_tvalid`=0, `busy`=0, counters 0.
  - After release, req1 and req0 both valid: req0 is granted first.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and default constants for the Ethernet transmit arbiter.
package eth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN,
        IFG
    } arb_state_t;

    localparam int ETH_MAX_LEN   = 1518;
    localparam int ETH_IFG_BYTES = 12;

endpackage

// File: rtl/eth_rr_arb.sv
// Combinational round-robin picker: the first requester with valid high,
// searching upward from the one after the last winner.
module eth_rr_arb
    import eth_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_i,
    output logic [$clog2(N_REQ)-1:0] grant_o,
    output logic                     any_o
);

    localparam int GW = $clog2(N_REQ);

    logic [GW-1:0] cand;
    logic          found;

    always_comb begin
        grant_o = '0;
        cand    = '0;
        found   = 1'b0;
        any_o   = |req_i;
        // k = N_REQ wraps back onto last_i itself, so a lone requester can win again.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = GW'((int'(last_i) + k) % N_REQ);
            if (!found && req_i[cand]) begin
                grant_o = cand;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular round-robin arbiter in front of the MAC transmit byte
// interface, with inter-frame gap, oversize truncation and frame statistics.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int IFG_CYCLES = ETH_IFG_BYTES,
    parameter int MAX_LEN    = ETH_MAX_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*N_REQ-1:0]       s_tdata,
    input  logic [N_REQ-1:0]         s_tvalid,
    input  logic [N_REQ-1:0]         s_tlast,
    output logic [N_REQ-1:0]         s_tready,
    output logic [7:0]               m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    output logic                     m_tuser,
    input  logic                     m_tready,
    output logic [$clog2(N_REQ)-1:0] grant,
    output logic                     busy,
    output logic [15:0]              frames_sent,
    output logic [15:0]              frames_trunc
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int IW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(MAX_LEN - 1);
    localparam logic [IW-1:0] IFG_LAST  = (IFG_CYCLES > 0) ? IW'(IFG_CYCLES - 1) : '0;
    localparam logic [GW-1:0] LAST_RST  = GW'(N_REQ - 1);
    localparam arb_state_t    END_STATE = (IFG_CYCLES > 0) ? IFG : IDLE;

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ifg_q, ifg_d;
    logic [15:0]   sent_q, sent_d;
    logic [15:0]   trunc_q, trunc_d;

    logic [GW-1:0] pick;
    logic          any_req;
    logic [7:0]    sel_data;
    logic          sel_valid;
    logic          sel_last;
    logic          at_max;

    eth_rr_arb #(
        .N_REQ (N_REQ)
    ) u_arb (
        .req_i   (s_tvalid),
        .last_i  (last_q),
        .grant_o (pick),
        .any_o   (any_req)
    );

    assign sel_data  = s_tdata[{grant_q, 3'b000} +: 8];
    assign sel_valid = s_tvalid[grant_q];
    assign sel_last  = s_tlast[grant_q];
    // The beat in flight is the MAX_LEN-th byte of the frame.
    assign at_max    = (cnt_q == CNT_LAST);

    assign grant        = grant_q;
    assign busy         = (state_q != IDLE);
    assign frames_sent  = sent_q;
    assign frames_trunc = trunc_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            ifg_q   <= '0;
            sent_q  <= '0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            ifg_q   <= ifg_d;
            sent_q  <= sent_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        ifg_d    = ifg_q;
        sent_d   = sent_q;
        trunc_d  = trunc_q;
        s_tready = '0;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                    state_d = XFER;
                end
            end

            XFER: begin
                m_tdata            = sel_data;
                m_tvalid           = sel_valid;
                s_tready[grant_q]  = m_tready;
                m_tlast            = sel_valid && (sel_last || at_max);
                m_tuser            = sel_valid && at_max && !sel_last;
                if (sel_valid && m_tready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (sel_last || at_max) begin
                        sent_d = sent_q + 16'd1;
                        ifg_d  = '0;
                        // A frame ending exactly at MAX_LEN is complete, not truncated.
                        if (!sel_last) begin
                            trunc_d = trunc_q + 16'd1;
                            state_d = DRAIN;
                        end else begin
                            state_d = END_STATE;
                        end
                    end
                end
            end

            DRAIN: begin
                s_tready[grant_q] = 1'b1;
                if (sel_valid && sel_last) begin
                    ifg_d   = '0;
                    state_d = END_STATE;
                end
            end

            IFG: begin
                if (ifg_q == IFG_LAST) begin
                    state_d = IDLE;
                end else begin
                    ifg_d = ifg_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: vector table, directed corner cases
// and randomized traffic checked against a frame-level reference model.
module tb_eth_tx_arbiter;

    localparam int N     = 2;
    localparam int IFG_N = 12;
    localparam int MAXL  = 1518;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [8*N-1:0]         s_tdata;
    logic [N-1:0]           s_tvalid;
    logic [N-1:0]           s_tlast;
    logic [N-1:0]           s_tready;
    logic [7:0]             m_tdata;
    logic                   m_tvalid;
    logic                   m_tlast;
    logic                   m_tuser;
    logic                   m_tready;
    logic [$clog2(N)-1:0]   grant;
    logic                   busy;
    logic [15:0]            frames_sent;
    logic [15:0]            frames_trunc;

    always #5 clk = ~clk;

    eth_tx_arbiter #(
        .N_REQ      (N),
        .IFG_CYCLES (IFG_N),
        .MAX_LEN    (MAXL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tlast      (s_tlast),
        .s_tready     (s_tready),
        .m_tdata      (m_tdata),
        .m_tvalid     (m_tvalid),
        .m_tlast      (m_tlast),
        .m_tuser      (m_tuser),
        .m_tready     (m_tready),
        .grant        (grant),
        .busy         (busy),
        .frames_sent  (frames_sent),
        .frames_trunc (frames_trunc)
    );

    typedef struct {
        logic [N-1:0] mask;
        int           exp_grant;
        int           exp_sent;
    } vec_t;

    vec_t tbl [7];

    int n_checks = 0;
    int n_pass   = 0;

    // Source streams (what each requester still has to offer) and the
    // reference copy of every frame, consumed by the model as bytes leave.
    logic [7:0] src_d   [N][$];
    bit         src_l   [N][$];
    logic [7:0] exp_d   [N][$];
    int         exp_len [N][$];

    bit           hold_en = 1'b0;
    bit           bp_en   = 1'b0;
    logic [N-1:0] hold    = '0;

    bit           in_frame;
    int           cur_g, cur_len, n_exp, idx;
    bit           cur_trunc, frame_bad;
    int           last_served;
    bit           prev_busy;
    logic [N-1:0] prev_valid;
    int           gap;
    bit           had_frame;
    int           sent_m, trunc_m;
    int           drained = 0;
    int           stray   = 0;
    bit           last_tuser;
    int           last_beat_cyc, idle_cyc;
    int           cyc = 0;
    int           grant_log [$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            if (src_d[r].size() > 0) begin
                s_tdata[8*r +: 8] = src_d[r][0];
                s_tlast[r]        = src_l[r][0];
                s_tvalid[r]       = !hold[r];
            end else begin
                s_tdata[8*r +: 8] = 8'h00;
                s_tlast[r]        = 1'b0;
                s_tvalid[r]       = 1'b0;
            end
        end
    endtask

    task automatic load_frame(input int r, input int len);
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            src_d[r].push_back(b);
            src_l[r].push_back(k == len - 1);
            exp_d[r].push_back(b);
        end
        exp_len[r].push_back(len);
        drive();
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int r = 0; r < N; r++) if (src_d[r].size() > 0) p = 1'b1;
        return p;
    endfunction

    // Round-robin rule: first valid requester after the last one served.
    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic reset_model();
        for (int r = 0; r < N; r++) begin
            src_d[r].delete();
            src_l[r].delete();
            exp_d[r].delete();
            exp_len[r].delete();
        end
        in_frame    = 1'b0;
        last_served = N - 1;
        prev_busy   = 1'b0;
        prev_valid  = '0;
        gap         = 0;
        had_frame   = 1'b0;
        sent_m      = 0;
        trunc_m     = 0;
        grant_log.delete();
        hold        = '0;
    endtask

    task automatic model_cycle();
        logic [7:0]   b;
        logic [N-1:0] others;
        int           eg;
        b = 8'h00;
        if (prev_busy && !busy) idle_cyc = cyc;
        if (busy && !prev_busy) begin
            eg = rr_pick(prev_valid, last_served);
            chk("arb_grant", int'(grant), eg);
            if (had_frame) chk("ifg_gap_min", (gap >= IFG_N + 1), 1);
            last_served = int'(grant);
            grant_log.push_back(int'(grant));
            if (exp_len[int'(grant)].size() == 0) begin
                chk("frame_pending", 0, 1);
            end else begin
                cur_g     = int'(grant);
                cur_len   = exp_len[cur_g].pop_front();
                n_exp     = (cur_len > MAXL) ? MAXL : cur_len;
                cur_trunc = (cur_len > MAXL);
                idx       = 0;
                frame_bad = 1'b0;
                in_frame  = 1'b1;
            end
        end
        if (in_frame) begin
            others        = s_tready;
            others[cur_g] = 1'b0;
            if (m_tvalid !== s_tvalid[cur_g] || s_tready[cur_g] !== m_tready || others != '0)
                frame_bad = 1'b1;
            if (m_tvalid && m_tready) begin
                if (exp_d[cur_g].size() == 0) frame_bad = 1'b1;
                else b = exp_d[cur_g].pop_front();
                idx++;
                if (m_tdata !== b || m_tlast !== (idx == n_exp)) frame_bad = 1'b1;
                if (idx == n_exp) begin
                    if (m_tuser !== cur_trunc) frame_bad = 1'b1;
                    chk("frame_ok", frame_bad, 0);
                    for (int k = n_exp; k < cur_len; k++)
                        if (exp_d[cur_g].size() > 0) b = exp_d[cur_g].pop_front();
                    sent_m++;
                    if (cur_trunc) trunc_m++;
                    last_tuser    = m_tuser;
                    last_beat_cyc = cyc;
                    in_frame      = 1'b0;
                    had_frame     = 1'b1;
                    gap           = 0;
                end
            end
        end else begin
            gap++;
            if (m_tvalid !== 1'b0) stray++;
            for (int r = 0; r < N; r++) if (s_tvalid[r] && s_tready[r]) drained++;
        end
        prev_busy  = busy;
        prev_valid = s_tvalid;
    endtask

    task automatic step();
        logic [N-1:0] hs;
        @(negedge clk);
        model_cycle();
        hs = s_tvalid & s_tready;
        @(posedge clk);
        #1;
        cyc++;
        for (int r = 0; r < N; r++) begin
            if (hs[r] && src_d[r].size() > 0) begin
                void'(src_d[r].pop_front());
                void'(src_l[r].pop_front());
            end
            hold[r] = hold_en && ($urandom_range(0, 3) == 0);
        end
        m_tready = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
        drive();
    endtask

    task automatic run_until_done(input int budget, input string nm);
        int n = 0;
        while ((pending() || in_frame || busy) && n < budget) begin
            step();
            n++;
        end
        chk(nm, (n < budget), 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        reset_model();
        drive();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int n, base, d0, nframes, ntrunc, len, r;

        tbl[0] = '{2'b11, 0, 1};
        tbl[1] = '{2'b11, 1, 2};
        tbl[2] = '{2'b01, 0, 3};
        tbl[3] = '{2'b01, 0, 4};
        tbl[4] = '{2'b10, 1, 5};
        tbl[5] = '{2'b11, 0, 6};
        tbl[6] = '{2'b11, 1, 7};

        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        do_reset();

        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tuser", m_tuser, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_frames_sent", frames_sent, 0);
        chk("rst_frames_trunc", frames_trunc, 0);

        // Arbitration vectors: one-byte frames, unserved offers withdrawn during IFG.
        for (int i = 0; i < 7; i++) begin
            base = sent_m;
            for (int q = 0; q < N; q++) if (tbl[i].mask[q]) load_frame(q, 1);
            n = 0;
            while (sent_m == base && n < 40) begin
                step();
                n++;
            end
            for (int q = 0; q < N; q++) begin
                src_d[q].delete();
                src_l[q].delete();
                exp_d[q].delete();
                exp_len[q].delete();
            end
            drive();
            chk("vec_grant", int'(grant), tbl[i].exp_grant);
            chk("vec_sent", frames_sent, tbl[i].exp_sent);
            run_until_done(40, "vec_idle");
        end

        // Single 64-byte frame, then exactly IFG_N idle cycles before IDLE.
        do_reset();
        load_frame(0, 64);
        run_until_done(200, "single_done");
        step();
        chk("single_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        chk("single_sent", frames_sent, 1);
        chk("single_tuser", last_tuser, 0);
        chk("single_idle_after", idle_cyc - last_beat_cyc, IFG_N + 1);

        // Contention: strict alternation of three frames each.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            load_frame(0, 60);
            load_frame(1, 60);
        end
        run_until_done(1000, "contention_done");
        for (int k = 0; k < 6; k++)
            chk("contention_order", (grant_log.size() > k) ? grant_log[k] : -1, k % 2);
        chk("contention_sent", frames_sent, 6);

        // Backpressure on a 100-byte frame from requester 1.
        bp_en = 1'b1;
        load_frame(1, 100);
        run_until_done(2000, "bp_done");
        bp_en = 1'b0;
        chk("bp_sent", frames_sent, 7);
        chk("bp_grant", grant, 1);

        // Oversize frame: truncated at MAX_LEN, remainder drained.
        d0 = drained;
        load_frame(0, 1600);
        run_until_done(4000, "trunc_done");
        chk("trunc_drained", drained - d0, 82);
        chk("trunc_tuser", last_tuser, 1);
        chk("trunc_count", frames_trunc, 1);
        chk("trunc_sent", frames_sent, 8);

        // Exact MAX_LEN frame: no truncation, no drain.
        d0 = drained;
        load_frame(0, 1518);
        run_until_done(4000, "exact_done");
        chk("exact_drained", drained - d0, 0);
        chk("exact_tuser", last_tuser, 0);
        chk("exact_trunc", frames_trunc, 1);
        chk("exact_sent", frames_sent, 9);

        // Reset in the middle of a frame.
        load_frame(0, 100);
        n = 0;
        while (!(in_frame && idx >= 30) && n < 200) begin
            step();
            n++;
        end
        chk("midrst_reached", (n < 200), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_m_tvalid", m_tvalid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_s_tready", s_tready, 0);
        chk("midrst_sent", frames_sent, 0);
        chk("midrst_trunc", frames_trunc, 0);
        reset_model();
        drive();
        rst = 1'b1;
        load_frame(1, 5);
        load_frame(0, 5);
        run_until_done(200, "midrst_after");
        chk("midrst_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
        chk("midrst_second", (grant_log.size() > 1) ? grant_log[1] : -1, 1);

        // Randomized traffic: valid gaps, backpressure, one oversize frame.
        do_reset();
        hold_en = 1'b1;
        bp_en   = 1'b1;
        nframes = 0;
        ntrunc  = 0;
        for (int k = 0; k < 30; k++) begin
            r   = int'($urandom_range(0, N - 1));
            len = (k == 12) ? 1530 : int'($urandom_range(1, 90));
            load_frame(r, len);
            nframes++;
            if (len > MAXL) ntrunc++;
        end
        run_until_done(40000, "random_done");
        hold_en = 1'b0;
        bp_en   = 1'b0;
        hold    = '0;
        drive();
        chk("random_model_sent", sent_m, nframes);
        chk("random_sent", frames_sent, nframes);
        chk("random_trunc", frames_trunc, ntrunc);
        chk("no_stray_output", stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
